// File: rtl/comparator_tree_pipe.sv
// ---------------------------------------------------------------------------
// comparator_tree_pipe
//   Pipelined, parametrised magnitude/equality comparator. Two WIDTH-bit
//   operands are reduced through a log2(WIDTH)-level binary tree producing
//   EQ, signed LT and unsigned LTu. Tree levels are registered in groups of
//   LVL_PER_STG levels, with the final level always registered; a partial
//   group (fewer levels) sits in the last stage. Stages are linked by a
//   valid/ready handshake with bubble collapsing. A TAG_W-bit user tag
//   travels with each compare.
//
// Optional feature macro: COMPTREE_MINMAX_EN
//   When defined, the operands ride along the pipe and the last stage also
//   registers signed/unsigned min and max of op1/op2.
//
// Ports
//   clk        in   1      clock
//   reset_n    in   1      asynchronous active-low reset (release is expected
//                          to come from a synchronizer in the clock domain)
//   in_valid   in   1      op1/op2/in_tag valid
//   in_ready   out  1      block accepts input this cycle
//   op1, op2   in   WIDTH  operands
//   in_tag     in   TAG_W  tag accompanying the operands
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts the result
//   EQ/LT/LTu  out  1      op1==op2, signed op1<op2, unsigned op1<op2
//   out_tag    out  TAG_W  tag of the presented result
//   min_s/max_s/min_u/max_u  out WIDTH  (COMPTREE_MINMAX_EN only)
// ---------------------------------------------------------------------------
module comparator_tree_pipe #(
    parameter int WIDTH       = 64,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             EQ,
    output logic             LT,
    output logic             LTu,
    output logic [TAG_W-1:0] out_tag
`ifdef COMPTREE_MINMAX_EN
    ,
    output logic [WIDTH-1:0] min_s,
    output logic [WIDTH-1:0] max_s,
    output logic [WIDTH-1:0] min_u,
    output logic [WIDTH-1:0] max_u
`endif
);

    localparam int LEVELS  = $clog2(WIDTH);
    localparam int LATENCY = (LEVELS + LVL_PER_STG - 1) / LVL_PER_STG;

    logic [LATENCY-1:0] w_valid;
    logic [LATENCY-1:0] w_ready;

    // Leaves: the signed chain differs from the unsigned one only at the MSB,
    // where a set sign bit in op1 against a clear one in op2 means op1 < op2.
    logic [WIDTH-1:0] w_leaf_eq;
    logic [WIDTH-1:0] w_leaf_lts;
    logic [WIDTH-1:0] w_leaf_ltu;

    assign w_leaf_eq  = ~(op1 ^ op2);
    assign w_leaf_ltu = ~op1 & op2;
    assign w_leaf_lts = {op1[WIDTH-1] & ~op2[WIDTH-1], w_leaf_ltu[WIDTH-2:0]};

    // ready_k = ~valid_k | ready_{k+1} with ready_last = out_ready, unrolled:
    // stage k is blocked only if it and every stage after it are full and
    // the consumer is stalling. Written flat to avoid a self-referencing vector.
    for (genvar k = 0; k < LATENCY; k++) begin : g_rdy
        assign w_ready[k] = ~(&w_valid[LATENCY-1:k]) | out_ready;
    end

    assign in_ready = w_ready[0];

    for (genvar k = 0; k < LATENCY; k++) begin : g_stg
        localparam int LV_LO = k * LVL_PER_STG;
        localparam int LV_HI = ((k + 1) * LVL_PER_STG > LEVELS) ? LEVELS : (k + 1) * LVL_PER_STG;
        localparam int NLV   = LV_HI - LV_LO;
        localparam int NI    = WIDTH >> LV_LO;
        localparam int NO    = WIDTH >> LV_HI;

        logic             w_in_valid;
        logic [TAG_W-1:0] w_in_tag;
        logic [NI-1:0]    w_in_eq;
        logic [NI-1:0]    w_in_lts;
        logic [NI-1:0]    w_in_ltu;
        logic [NI-1:0]    w_eq;
        logic [NI-1:0]    w_lts;
        logic [NI-1:0]    w_ltu;

        logic             r_valid;
        logic [TAG_W-1:0] r_tag;
        logic [NO-1:0]    r_eq;
        logic [NO-1:0]    r_lts;
        logic [NO-1:0]    r_ltu;

`ifdef COMPTREE_MINMAX_EN
        logic [WIDTH-1:0] w_in_op1;
        logic [WIDTH-1:0] w_in_op2;
`endif

        if (k == 0) begin : g_src
            assign w_in_valid = in_valid;
            assign w_in_tag   = in_tag;
            assign w_in_eq    = w_leaf_eq;
            assign w_in_lts   = w_leaf_lts;
            assign w_in_ltu   = w_leaf_ltu;
`ifdef COMPTREE_MINMAX_EN
            assign w_in_op1   = op1;
            assign w_in_op2   = op2;
`endif
        end else begin : g_src
            assign w_in_valid = g_stg[k-1].r_valid;
            assign w_in_tag   = g_stg[k-1].r_tag;
            assign w_in_eq    = g_stg[k-1].r_eq;
            assign w_in_lts   = g_stg[k-1].r_lts;
            assign w_in_ltu   = g_stg[k-1].r_ltu;
`ifdef COMPTREE_MINMAX_EN
            assign w_in_op1   = g_stg[k-1].g_mm.r_op1;
            assign w_in_op2   = g_stg[k-1].g_mm.r_op2;
`endif
        end

        // In-place reduction of NLV levels: node i at the next level merges
        // hi = 2i+1 and lo = 2i. Ascending i only ever overwrites slots that
        // have already been consumed; lt is formed before eq[i] is replaced.
        always_comb begin
            w_eq  = w_in_eq;
            w_lts = w_in_lts;
            w_ltu = w_in_ltu;
            for (int lv = 0; lv < NLV; lv++) begin
                for (int i = 0; i < (NI >> (lv + 1)); i++) begin
                    w_lts[i] = w_lts[2*i+1] | (w_eq[2*i+1] & w_lts[2*i]);
                    w_ltu[i] = w_ltu[2*i+1] | (w_eq[2*i+1] & w_ltu[2*i]);
                    w_eq[i]  = w_eq[2*i+1] & w_eq[2*i];
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= 1'b0;
                r_tag   <= '0;
                r_eq    <= '0;
                r_lts   <= '0;
                r_ltu   <= '0;
            end else if (w_ready[k]) begin
                r_valid <= w_in_valid;
                if (w_in_valid) begin
                    r_tag <= w_in_tag;
                    r_eq  <= w_eq[NO-1:0];
                    r_lts <= w_lts[NO-1:0];
                    r_ltu <= w_ltu[NO-1:0];
                end
            end
        end

        assign w_valid[k] = r_valid;

`ifdef COMPTREE_MINMAX_EN
        if (k == LATENCY - 1) begin : g_mm
            logic [WIDTH-1:0] r_min_s;
            logic [WIDTH-1:0] r_max_s;
            logic [WIDTH-1:0] r_min_u;
            logic [WIDTH-1:0] r_max_u;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_min_s <= '0;
                    r_max_s <= '0;
                    r_min_u <= '0;
                    r_max_u <= '0;
                end else if (w_ready[k] && w_in_valid) begin
                    r_min_s <= w_lts[0] ? w_in_op1 : w_in_op2;
                    r_max_s <= w_lts[0] ? w_in_op2 : w_in_op1;
                    r_min_u <= w_ltu[0] ? w_in_op1 : w_in_op2;
                    r_max_u <= w_ltu[0] ? w_in_op2 : w_in_op1;
                end
            end
        end else begin : g_mm
            logic [WIDTH-1:0] r_op1;
            logic [WIDTH-1:0] r_op2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_op1 <= '0;
                    r_op2 <= '0;
                end else if (w_ready[k] && w_in_valid) begin
                    r_op1 <= w_in_op1;
                    r_op2 <= w_in_op2;
                end
            end
        end
`endif
    end

    assign out_valid = g_stg[LATENCY-1].r_valid;
    assign out_tag   = g_stg[LATENCY-1].r_tag;
    assign EQ        = g_stg[LATENCY-1].r_eq[0];
    assign LT        = g_stg[LATENCY-1].r_lts[0];
    assign LTu       = g_stg[LATENCY-1].r_ltu[0];

`ifdef COMPTREE_MINMAX_EN
    assign min_s = g_stg[LATENCY-1].g_mm.r_min_s;
    assign max_s = g_stg[LATENCY-1].g_mm.r_max_s;
    assign min_u = g_stg[LATENCY-1].g_mm.r_min_u;
    assign max_u = g_stg[LATENCY-1].g_mm.r_max_u;
`endif

endmodule

// File: tb/tb_comparator_tree_pipe.sv
// Testbench for comparator_tree_pipe (WIDTH=64, LVL_PER_STG=2, TAG_W=4).
// Accepted beats are pushed into a scoreboard with values from a plain
// arithmetic reference; a negedge monitor pops and compares on each output
// transfer, and also checks in_ready against pipe occupancy, stall
// stability, reset values and (when the consumer never stalls) latency.
module tb_comparator_tree_pipe;
    localparam int WIDTH       = 64;
    localparam int LVL_PER_STG = 2;
    localparam int TAG_W       = 4;
    localparam int LATENCY     = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] op1 = '0;
    logic [WIDTH-1:0] op2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             EQ;
    logic             LT;
    logic             LTu;
    logic [TAG_W-1:0] out_tag;
`ifdef COMPTREE_MINMAX_EN
    logic [WIDTH-1:0] min_s, max_s, min_u, max_u;
`endif

    comparator_tree_pipe #(
        .WIDTH(WIDTH), .LVL_PER_STG(LVL_PER_STG), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .EQ(EQ), .LT(LT), .LTu(LTu), .out_tag(out_tag)
`ifdef COMPTREE_MINMAX_EN
        , .min_s(min_s), .max_s(max_s), .min_u(min_u), .max_u(max_u)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             eq;
        logic             lt;
        logic             ltu;
        logic [TAG_W-1:0] tag;
        int               acc;
`ifdef COMPTREE_MINMAX_EN
        logic [WIDTH-1:0] mins, maxs, minu, maxu;
`endif
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   nostall = 1'b0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    logic             stall_pend = 1'b0;
    logic [TAG_W+2:0] held = '0;
`ifdef COMPTREE_MINMAX_EN
    logic [4*WIDTH-1:0] held_mm = '0;
`endif

    always @(negedge clk) begin
        exp_t e;
        exp_t s;
        if (!reset_n) begin
            q.delete();
            stall_pend = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_flags", {EQ, LT, LTu}, 0);
            chk("rst_tag", out_tag, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            chk("in_ready", in_ready, !(q.size() == LATENCY && !out_ready));
            if (stall_pend) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {EQ, LT, LTu, out_tag}, held);
`ifdef COMPTREE_MINMAX_EN
                chk("stall_hold_mm", {min_s, max_s, min_u, max_u}, held_mm);
`endif
            end
            stall_pend = out_valid & ~out_ready;
            held = {EQ, LT, LTu, out_tag};
`ifdef COMPTREE_MINMAX_EN
            held_mm = {min_s, max_s, min_u, max_u};
`endif
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_out: got tag %0h expected no output (cycle %0d)", out_tag, cyc);
                end else begin
                    e = q.pop_front();
                    chk("EQ", EQ, e.eq);
                    chk("LT", LT, e.lt);
                    chk("LTu", LTu, e.ltu);
                    chk("out_tag", out_tag, e.tag);
`ifdef COMPTREE_MINMAX_EN
                    chk("min_s", min_s, e.mins);
                    chk("max_s", max_s, e.maxs);
                    chk("min_u", min_u, e.minu);
                    chk("max_u", max_u, e.maxu);
`endif
                    if (nostall) chk("latency", cyc - e.acc, LATENCY);
                end
            end
            if (in_valid && in_ready) begin
                s.eq  = (op1 == op2);
                s.lt  = ($signed(op1) < $signed(op2));
                s.ltu = (op1 < op2);
                s.tag = in_tag;
                s.acc = cyc;
`ifdef COMPTREE_MINMAX_EN
                s.mins = s.lt  ? op1 : op2;
                s.maxs = s.lt  ? op2 : op1;
                s.minu = s.ltu ? op1 : op2;
                s.maxu = s.ltu ? op2 : op1;
`endif
                q.push_back(s);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [TAG_W-1:0] t);
        int k;
        op1 = a;
        op2 = b;
        in_tag = t;
        in_valid = 1'b1;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed vectors, consumer always ready
        out_ready = 1'b1;
        nostall = 1'b1;
        send(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 4'd5);
        send(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 4'd6);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'd7);
        send(64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 4'd8);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 4'd9);
        send(64'h0, 64'h0, 4'd10);
        drain();

        // Back-to-back random stream, tags wrap 0..15
        for (int i = 0; i < 8192; i++) begin
            a = rand_op();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (64'h1 << $urandom_range(0, WIDTH - 1));
                default: b = rand_op();
            endcase
            send(a, b, 4'(i));
        end
        drain();

        // Reset with three beats in flight
        nostall = 1'b0;
        out_ready = 1'b0;
        send(rand_op(), rand_op(), 4'd1);
        send(rand_op(), rand_op(), 4'd2);
        send(rand_op(), rand_op(), 4'd3);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        nostall = 1'b1;
        send(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 4'd11);
        drain();

        // Random backpressure with continuous input
        nostall = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            a = rand_op();
            b = ($urandom_range(0, 3) == 0) ? a : rand_op();
            send(a, b, 4'(i));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        repeat (5) @(posedge clk);
        chk("final_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
